// File: rtl/csr_port_arbiter_pkg.sv
// csr_port_arbiter_pkg: shared state encoding and bus widths for the CSR port arbiter.
`default_nettype none

package csr_port_arbiter_pkg;

  localparam int CSR_ADDR_W = 12;
  localparam int CSR_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_INST_OWN     = 2'd1,
    ST_TRAP_OWN     = 2'd2,
    ST_TRAP_RELEASE = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/csr_port_arbiter_if.sv
// csr_port_arbiter_if: trap-side, pipeline-side and CSR-file-side signals of the arbiter.
`default_nettype none

interface csr_port_arbiter_if;
  import csr_port_arbiter_pkg::*;

  logic                  trap_req;
  logic                  trap_write_enable;
  logic [CSR_ADDR_W-1:0] trap_address;
  logic [CSR_DATA_W-1:0] trap_write_data;
  logic                  trap_grant;
  logic [CSR_DATA_W-1:0] trap_read_data;

  logic                  inst_req;
  logic                  inst_write_enable;
  logic [CSR_ADDR_W-1:0] inst_address;
  logic [CSR_DATA_W-1:0] inst_write_data;
  logic                  inst_grant;
  logic [CSR_DATA_W-1:0] inst_read_data;
  logic                  inst_stall;

  logic                  csr_write_enable;
  logic [CSR_ADDR_W-1:0] csr_address;
  logic [CSR_DATA_W-1:0] csr_write_data;
  logic [CSR_DATA_W-1:0] csr_read_data;

  logic                  lock_timeout;

  // Requesters and the CSR file
  modport master (
    output trap_req, trap_write_enable, trap_address, trap_write_data,
    input  trap_grant, trap_read_data,
    output inst_req, inst_write_enable, inst_address, inst_write_data,
    input  inst_grant, inst_read_data, inst_stall,
    input  csr_write_enable, csr_address, csr_write_data,
    output csr_read_data,
    input  lock_timeout
  );

  // The arbiter itself
  modport slave (
    input  trap_req, trap_write_enable, trap_address, trap_write_data,
    output trap_grant, trap_read_data,
    input  inst_req, inst_write_enable, inst_address, inst_write_data,
    output inst_grant, inst_read_data, inst_stall,
    output csr_write_enable, csr_address, csr_write_data,
    input  csr_read_data,
    output lock_timeout
  );

endinterface

`default_nettype wire

// File: rtl/csr_port_arbiter_lock_timer.sv
// csr_port_arbiter_lock_timer: bounds trap ownership of the port and tracks the timeout/re-arm flags.
`default_nettype none

module csr_port_arbiter_lock_timer #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic trap_req,
  input  wire logic enter_own,
  input  wire logic in_own,
  output logic      expire,
  output logic      lock_timeout,
  output logic      trap_armed
);

  localparam int              CNT_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LOCK_TIMEOUT);

  logic [CNT_W-1:0] lock_count;

  assign expire = in_own && (lock_count == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_count <= '0;
    end else if (enter_own) begin
      lock_count <= '0;
    end else if (in_own && (lock_count != CNT_MAX)) begin
      lock_count <= lock_count + 1'b1;
    end
  end

  // A requester that has been forcibly evicted must drop trap_req once before it may own the port again
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_timeout <= 1'b0;
      trap_armed   <= 1'b1;
    end else begin
      if (expire) begin
        lock_timeout <= 1'b1;
      end
      if (!trap_req) begin
        trap_armed <= 1'b1;
      end else if (expire) begin
        trap_armed <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/csr_port_arbiter.sv
// csr_port_arbiter: shares the CSR-file port between the trap controller (priority, locked) and the pipeline.
`default_nettype none

module csr_port_arbiter
  import csr_port_arbiter_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  csr_port_arbiter_if.slave  bus
);

  arb_state_e state;
  arb_state_e state_next;
  logic       expire;
  logic       trap_armed;
  logic       trap_wins;
  logic       enter_own;

  assign trap_wins = bus.trap_req && trap_armed;
  assign enter_own = (state_next == ST_TRAP_OWN) && (state != ST_TRAP_OWN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (trap_wins)         state_next = ST_TRAP_OWN;
        else if (bus.inst_req) state_next = ST_INST_OWN;
      end
      ST_INST_OWN: begin
        state_next = trap_wins ? ST_TRAP_OWN : ST_IDLE;
      end
      ST_TRAP_OWN: begin
        if (!bus.trap_req || expire) state_next = ST_TRAP_RELEASE;
      end
      ST_TRAP_RELEASE: begin
        if (trap_wins)         state_next = ST_TRAP_OWN;
        else if (bus.inst_req) state_next = ST_INST_OWN;
        else                   state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.trap_grant       = 1'b0;
    bus.inst_grant       = 1'b0;
    bus.trap_read_data   = '0;
    bus.inst_read_data   = '0;
    bus.csr_write_enable = 1'b0;
    bus.csr_address      = '0;
    bus.csr_write_data   = '0;
    case (state)
      ST_INST_OWN: begin
        bus.inst_grant       = 1'b1;
        bus.inst_read_data   = bus.csr_read_data;
        bus.csr_write_enable = bus.inst_write_enable;
        bus.csr_address      = bus.inst_address;
        bus.csr_write_data   = bus.inst_write_data;
      end
      ST_TRAP_OWN: begin
        bus.trap_grant       = 1'b1;
        bus.trap_read_data   = bus.csr_read_data;
        bus.csr_write_enable = bus.trap_write_enable;
        bus.csr_address      = bus.trap_address;
        bus.csr_write_data   = bus.trap_write_data;
      end
      default: ;
    endcase
  end

  // Gated by rst so the stall also drops the instant reset asserts
  assign bus.inst_stall = bus.inst_req && !bus.inst_grant && rst;

  csr_port_arbiter_lock_timer #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT)
  ) u_lock_timer (
    .clk          (clk),
    .rst          (rst),
    .trap_req     (bus.trap_req),
    .enter_own    (enter_own),
    .in_own       (state == ST_TRAP_OWN),
    .expire       (expire),
    .lock_timeout (bus.lock_timeout),
    .trap_armed   (trap_armed)
  );

endmodule

`default_nettype wire

// File: tb/tb_csr_port_arbiter.sv
// tb_csr_port_arbiter: directed vectors with hand-computed expectations for csr_port_arbiter.
`default_nettype none

module tb_csr_port_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  int   grant_cycles;

  csr_port_arbiter_if bus ();

  csr_port_arbiter #(
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.trap_req          = 1'b0;
    bus.trap_write_enable = 1'b0;
    bus.trap_address      = '0;
    bus.trap_write_data   = '0;
    bus.inst_req          = 1'b0;
    bus.inst_write_enable = 1'b0;
    bus.inst_address      = '0;
    bus.inst_write_data   = '0;
    bus.csr_read_data     = '0;
  endtask

  task automatic trap_drive(input logic we, input logic [11:0] addr, input logic [31:0] data);
    bus.trap_write_enable = we;
    bus.trap_address      = addr;
    bus.trap_write_data   = data;
  endtask

  task automatic inst_drive(input logic we, input logic [11:0] addr, input logic [31:0] data);
    bus.inst_req          = 1'b1;
    bus.inst_write_enable = we;
    bus.inst_address      = addr;
    bus.inst_write_data   = data;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    rst = 1'b0;
    #12;
    check_eq("reset_trap_grant", 32'(bus.trap_grant), 32'd0);
    check_eq("reset_inst_grant", 32'(bus.inst_grant), 32'd0);
    check_eq("reset_csr_we", 32'(bus.csr_write_enable), 32'd0);
    check_eq("reset_csr_addr", 32'(bus.csr_address), 32'd0);
    check_eq("reset_lock_timeout", 32'(bus.lock_timeout), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Pipeline-only write to 0x340
    inst_drive(1'b1, 12'h340, 32'hDEAD_BEEF);
    settle();
    check_eq("pipe_idle_stall", 32'(bus.inst_stall), 32'd1);
    check_eq("pipe_idle_we", 32'(bus.csr_write_enable), 32'd0);
    tick();
    bus.csr_read_data = 32'h0000_1234;
    settle();
    check_eq("pipe_grant", 32'(bus.inst_grant), 32'd1);
    check_eq("pipe_we", 32'(bus.csr_write_enable), 32'd1);
    check_eq("pipe_addr", 32'(bus.csr_address), 32'h340);
    check_eq("pipe_wdata", bus.csr_write_data, 32'hDEAD_BEEF);
    check_eq("pipe_rdata", bus.inst_read_data, 32'h0000_1234);
    check_eq("pipe_stall_gone", 32'(bus.inst_stall), 32'd0);
    clear_inputs();
    tick();
    check_eq("pipe_done_grant", 32'(bus.inst_grant), 32'd0);
    check_eq("pipe_done_we", 32'(bus.csr_write_enable), 32'd0);

    // Simultaneous trap and inst requests, then a full trap sequence
    bus.trap_req = 1'b1;
    inst_drive(1'b1, 12'h300, 32'h0000_0008);
    settle();
    check_eq("sim_idle_stall", 32'(bus.inst_stall), 32'd1);
    tick();
    trap_drive(1'b0, 12'h305, 32'h0);
    bus.csr_read_data = 32'h1000_AA00;
    settle();
    check_eq("sim_trap_grant", 32'(bus.trap_grant), 32'd1);
    check_eq("sim_inst_grant", 32'(bus.inst_grant), 32'd0);
    check_eq("sim_stall", 32'(bus.inst_stall), 32'd1);
    check_eq("mtvec_addr", 32'(bus.csr_address), 32'h305);
    check_eq("mtvec_we", 32'(bus.csr_write_enable), 32'd0);
    check_eq("mtvec_rdata", bus.trap_read_data, 32'h1000_AA00);
    check_eq("mtvec_inst_rdata", bus.inst_read_data, 32'd0);
    tick();
    trap_drive(1'b1, 12'h341, 32'h0000_1100);
    settle();
    check_eq("mepc_we", 32'(bus.csr_write_enable), 32'd1);
    check_eq("mepc_addr", 32'(bus.csr_address), 32'h341);
    check_eq("mepc_data", bus.csr_write_data, 32'h0000_1100);
    check_eq("mepc_stall", 32'(bus.inst_stall), 32'd1);
    tick();
    trap_drive(1'b1, 12'h342, 32'd11);
    settle();
    check_eq("mcause_addr", 32'(bus.csr_address), 32'h342);
    check_eq("mcause_data", bus.csr_write_data, 32'd11);
    bus.trap_req = 1'b0;
    trap_drive(1'b0, 12'h0, 32'h0);
    tick();
    check_eq("rel_trap_grant", 32'(bus.trap_grant), 32'd0);
    check_eq("rel_inst_grant", 32'(bus.inst_grant), 32'd0);
    check_eq("rel_stall", 32'(bus.inst_stall), 32'd1);
    check_eq("rel_addr", 32'(bus.csr_address), 32'd0);
    tick();
    check_eq("post_trap_inst_grant", 32'(bus.inst_grant), 32'd1);
    check_eq("post_trap_addr", 32'(bus.csr_address), 32'h300);
    check_eq("post_trap_we", 32'(bus.csr_write_enable), 32'd1);
    clear_inputs();
    tick();

    // Back-to-back trap / MRET with a pending inst request
    bus.trap_req = 1'b1;
    tick();
    check_eq("b2b_first_grant", 32'(bus.trap_grant), 32'd1);
    bus.trap_req = 1'b0;
    inst_drive(1'b0, 12'h301, 32'h0);
    tick();
    check_eq("b2b_release_trap", 32'(bus.trap_grant), 32'd0);
    bus.trap_req = 1'b1;
    tick();
    check_eq("b2b_regrant", 32'(bus.trap_grant), 32'd1);
    check_eq("b2b_no_inst", 32'(bus.inst_grant), 32'd0);
    bus.trap_req = 1'b0;
    tick();
    tick();
    check_eq("b2b_inst_after", 32'(bus.inst_grant), 32'd1);
    clear_inputs();
    tick();

    // Stuck trap requester with a pending inst request
    bus.trap_req = 1'b1;
    inst_drive(1'b1, 12'h302, 32'h5);
    grant_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.trap_grant) grant_cycles++;
    end
    check_eq("stuck_grant_cycles", 32'(grant_cycles), 32'd16);
    check_eq("stuck_no_timeout_yet", 32'(bus.lock_timeout), 32'd0);
    tick();
    check_eq("stuck_released", 32'(bus.trap_grant), 32'd0);
    check_eq("stuck_timeout", 32'(bus.lock_timeout), 32'd1);
    tick();
    check_eq("stuck_inst_grant", 32'(bus.inst_grant), 32'd1);
    check_eq("stuck_inst_addr", 32'(bus.csr_address), 32'h302);
    bus.inst_req = 1'b0;
    tick();
    check_eq("stuck_no_regrab_a", 32'(bus.trap_grant), 32'd0);
    tick();
    check_eq("stuck_no_regrab_b", 32'(bus.trap_grant), 32'd0);
    bus.trap_req = 1'b0;
    tick();
    bus.trap_req = 1'b1;
    tick();
    check_eq("rearmed_grant", 32'(bus.trap_grant), 32'd1);
    check_eq("timeout_sticky", 32'(bus.lock_timeout), 32'd1);

    // Asynchronous reset in the middle of a trap write
    tick();
    trap_drive(1'b1, 12'h341, 32'h0000_1100);
    settle();
    check_eq("prerst_we", 32'(bus.csr_write_enable), 32'd1);
    rst = 1'b0;
    settle();
    check_eq("async_rst_we", 32'(bus.csr_write_enable), 32'd0);
    check_eq("async_rst_grant", 32'(bus.trap_grant), 32'd0);
    check_eq("async_rst_addr", 32'(bus.csr_address), 32'd0);
    check_eq("async_rst_timeout", 32'(bus.lock_timeout), 32'd0);
    clear_inputs();
    tick();
    rst = 1'b1;
    tick();
    check_eq("after_rst_idle", 32'(bus.trap_grant | bus.inst_grant), 32'd0);
    inst_drive(1'b0, 12'h340, 32'h0);
    tick();
    check_eq("after_rst_inst_grant", 32'(bus.inst_grant), 32'd1);
    clear_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
